pio_rx_req_engine: RTL and testbench

- Receive-side request engine for the PCIe PIO BAR.
- Parses memory TLPs arriving on the 64-bit AXI-Stream RX interface from the PCIe core and turns each one into a single access on the user register file:
  - a write strobe with address, byte enables and data;
  - or a read address plus a completion request that the TX completion engine consumes.
- Sits between the PCIe hard-block RX port and the register file; it is the initiating side of that register file's read/write interface.

---
 rtl/pio_rx_req_engine.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_pio_rx_req_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_rx_req_engine.sv
// Receive-side request engine for the PCIe PIO BAR: turns 1-DW memory TLPs into register-file accesses.
// Optional saturating dropped-TLP counter is built when PIO_RX_DISCARD_CNT_EN is defined.
module pio_rx_req_engine #(
  parameter int TCQ    = 1,
  parameter int REG_AW = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       rx_tdata,
  input  logic [7:0]        rx_tkeep,
  input  logic              rx_tlast,
  input  logic              rx_tvalid,
  output logic              rx_tready,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_be,
  output logic [31:0]       wr_data,
  output logic              wr_en,
  input  logic              wr_busy,
  output logic [REG_AW-1:0] rd_addr,
  output logic [3:0]        rd_be,
  output logic              req_compl,
  input  logic              compl_done,
  output logic [2:0]        req_tc,
  output logic              req_td,
  output logic              req_ep,
  output logic [1:0]        req_attr,
  output logic [9:0]        req_len,
  output logic [15:0]       req_rid,
  output logic [7:0]        req_tag,
  output logic [6:0]        req_addr,
  output logic [15:0]       discard_cnt
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    MRD32    = 4'd1,
    MRD64    = 4'd2,
    MWR32    = 4'd3,
    MWR64_H  = 4'd4,
    MWR64_D  = 4'd5,
    WR_WAIT  = 4'd6,
    CPL_WAIT = 4'd7,
    DISCARD  = 4'd8
  } state_t;

  localparam logic [1:0] FMT_MRD32 = 2'b00;
  localparam logic [1:0] FMT_MRD64 = 2'b01;
  localparam logic [1:0] FMT_MWR32 = 2'b10;

  function automatic logic [31:0] byte_swap(input logic [31:0] dw);
    return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
  endfunction

  state_t state_r;
  state_t state_nxt_s;

  logic              tready_s;
  logic              hdr_lat_s;
  logic              rd_lat_s;
  logic              wr_addr_lat_s;
  logic              wr_data_lat_s;
  logic              addr_hi_s;
  logic              data_hi_s;
  logic              wr_fire_s;
  logic              cpl_fire_s;
  logic              drop_s;
  logic              hdr_ok_s;
  logic [1:0]        hdr_fmt_s;
  logic [31:0]       dw_addr_s;
  logic [31:0]       dw_data_s;

  logic [REG_AW-1:0] wr_addr_r;
  logic [7:0]        wr_be_r;
  logic [31:0]       wr_data_r;
  logic              wr_en_r;
  logic [REG_AW-1:0] rd_addr_r;
  logic [3:0]        rd_be_r;
  logic              req_compl_r;
  logic [2:0]        req_tc_r;
  logic              req_td_r;
  logic              req_ep_r;
  logic [1:0]        req_attr_r;
  logic [9:0]        req_len_r;
  logic [15:0]       req_rid_r;
  logic [7:0]        req_tag_r;
  logic [6:0]        req_addr_r;

  // Only single-DW memory requests are serviced; anything else is drained.
  assign hdr_fmt_s = rx_tdata[30:29];
  assign hdr_ok_s  = (rx_tdata[28:24] == 5'b00000) && (rx_tdata[9:0] == 10'd1);
  assign dw_addr_s = addr_hi_s ? rx_tdata[63:32] : rx_tdata[31:0];
  assign dw_data_s = data_hi_s ? rx_tdata[63:32] : rx_tdata[31:0];

  assign rx_tready = rst_n & tready_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-beat capture strobes.
  always_comb begin
    state_nxt_s   = state_r;
    tready_s      = 1'b1;
    hdr_lat_s     = 1'b0;
    rd_lat_s      = 1'b0;
    wr_addr_lat_s = 1'b0;
    wr_data_lat_s = 1'b0;
    addr_hi_s     = 1'b0;
    data_hi_s     = 1'b0;
    wr_fire_s     = 1'b0;
    cpl_fire_s    = 1'b0;
    drop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_tvalid) begin
          hdr_lat_s = 1'b1;
          if (rx_tlast) begin
            drop_s      = 1'b1;
            state_nxt_s = IDLE;
          end else if (hdr_ok_s) begin
            case (hdr_fmt_s)
              FMT_MRD32: state_nxt_s = MRD32;
              FMT_MRD64: state_nxt_s = MRD64;
              FMT_MWR32: state_nxt_s = MWR32;
              default:   state_nxt_s = MWR64_H;
            endcase
          end else begin
            drop_s      = 1'b1;
            state_nxt_s = DISCARD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MRD32, MRD64: begin
        addr_hi_s = (state_r == MRD64);
        if (rx_tvalid) begin
          rd_lat_s    = 1'b1;
          cpl_fire_s  = 1'b1;
          state_nxt_s = CPL_WAIT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      MWR32: begin
        data_hi_s = 1'b1;
        if (rx_tvalid) begin
          wr_addr_lat_s = 1'b1;
          wr_data_lat_s = 1'b1;
          wr_fire_s     = 1'b1;
          state_nxt_s   = WR_WAIT;
        end else begin
          state_nxt_s = MWR32;
        end
      end
      MWR64_H: begin
        addr_hi_s = 1'b1;
        if (rx_tvalid && rx_tlast) begin
          drop_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (rx_tvalid) begin
          wr_addr_lat_s = 1'b1;
          state_nxt_s   = MWR64_D;
        end else begin
          state_nxt_s = MWR64_H;
        end
      end
      MWR64_D: begin
        if (rx_tvalid) begin
          wr_data_lat_s = 1'b1;
          wr_fire_s     = 1'b1;
          state_nxt_s   = WR_WAIT;
        end else begin
          state_nxt_s = MWR64_D;
        end
      end
      WR_WAIT: begin
        tready_s = 1'b0;
        // Strobe cycle always counts as busy, which spaces back-to-back writes.
        if (!wr_en_r && !wr_busy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WR_WAIT;
        end
      end
      CPL_WAIT: begin
        tready_s = 1'b0;
        if (compl_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CPL_WAIT;
        end
      end
      DISCARD: begin
        if (rx_tvalid && rx_tlast) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DISCARD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Request fields, register-file address/data and one-cycle strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_r   <= '0;
      wr_be_r     <= 8'h00;
      wr_data_r   <= 32'h0000_0000;
      wr_en_r     <= 1'b0;
      rd_addr_r   <= '0;
      rd_be_r     <= 4'h0;
      req_compl_r <= 1'b0;
      req_tc_r    <= 3'd0;
      req_td_r    <= 1'b0;
      req_ep_r    <= 1'b0;
      req_attr_r  <= 2'd0;
      req_len_r   <= 10'd0;
      req_rid_r   <= 16'h0000;
      req_tag_r   <= 8'h00;
      req_addr_r  <= 7'd0;
    end else begin
      wr_en_r     <= wr_fire_s;
      req_compl_r <= cpl_fire_s;
      if (hdr_lat_s) begin
        req_tc_r   <= rx_tdata[22:20];
        req_td_r   <= rx_tdata[15];
        req_ep_r   <= rx_tdata[14];
        req_attr_r <= rx_tdata[13:12];
        req_len_r  <= rx_tdata[9:0];
        req_rid_r  <= rx_tdata[63:48];
        req_tag_r  <= rx_tdata[47:40];
        wr_be_r    <= rx_tdata[39:32];
      end
      if (rd_lat_s) begin
        rd_addr_r  <= dw_addr_s[REG_AW+1:2];
        rd_be_r    <= wr_be_r[3:0];
        req_addr_r <= dw_addr_s[6:0];
      end
      if (wr_addr_lat_s) begin
        wr_addr_r <= dw_addr_s[REG_AW+1:2];
      end
      if (wr_data_lat_s) begin
        wr_data_r <= byte_swap(dw_data_s);
      end
    end
  end

  assign wr_addr   = wr_addr_r;
  assign wr_be     = wr_be_r;
  assign wr_data   = wr_data_r;
  assign wr_en     = wr_en_r;
  assign rd_addr   = rd_addr_r;
  assign rd_be     = rd_be_r;
  assign req_compl = req_compl_r;
  assign req_tc    = req_tc_r;
  assign req_td    = req_td_r;
  assign req_ep    = req_ep_r;
  assign req_attr  = req_attr_r;
  assign req_len   = req_len_r;
  assign req_rid   = req_rid_r;
  assign req_tag   = req_tag_r;
  assign req_addr  = req_addr_r;

`ifdef PIO_RX_DISCARD_CNT_EN
  logic [15:0] discard_cnt_r;

  // Saturating count of TLPs dropped without a register access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      discard_cnt_r <= 16'h0000;
    end else if (drop_s && (discard_cnt_r != 16'hFFFF)) begin
      discard_cnt_r <= discard_cnt_r + 16'h0001;
    end else begin
      discard_cnt_r <= discard_cnt_r;
    end
  end

  assign discard_cnt = discard_cnt_r;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
  assign discard_cnt   = 16'h0000;
`endif

  // Keep, unused header bits and the simulation delay parameter have no logic behind them.
  logic unused_s;
  assign unused_s = ^{rx_tkeep, rx_tdata, (TCQ != 0)};

endmodule

// File: tb/tb_pio_rx_req_engine.sv
// Directed scoreboard bench for pio_rx_req_engine: expected accesses are queued as TLPs are sent.
module tb_pio_rx_req_engine;

  localparam int REG_AW = 11;
`ifdef PIO_RX_DISCARD_CNT_EN
  localparam int DROP_STEP = 1;
`else
  localparam int DROP_STEP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [63:0]       rx_tdata;
  logic [7:0]        rx_tkeep;
  logic              rx_tlast;
  logic              rx_tvalid;
  logic              rx_tready;
  logic [REG_AW-1:0] wr_addr;
  logic [7:0]        wr_be;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic              wr_busy;
  logic [REG_AW-1:0] rd_addr;
  logic [3:0]        rd_be;
  logic              req_compl;
  logic              compl_done;
  logic [2:0]        req_tc;
  logic              req_td;
  logic              req_ep;
  logic [1:0]        req_attr;
  logic [9:0]        req_len;
  logic [15:0]       req_rid;
  logic [7:0]        req_tag;
  logic [6:0]        req_addr;
  logic [15:0]       discard_cnt;

  typedef struct {
    bit          is_wr;
    logic [10:0] addr;
    logic [7:0]  be;
    logic [31:0] data;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [6:0]  laddr;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  int   last_cpl_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pio_rx_req_engine #(.TCQ(1), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en), .wr_busy(wr_busy),
    .rd_addr(rd_addr), .rd_be(rd_be), .req_compl(req_compl), .compl_done(compl_done),
    .req_tc(req_tc), .req_td(req_td), .req_ep(req_ep), .req_attr(req_attr),
    .req_len(req_len), .req_rid(req_rid), .req_tag(req_tag), .req_addr(req_addr),
    .discard_cnt(discard_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_wr(input logic [10:0] a, input logic [7:0] be, input logic [31:0] d);
    exp_t e;
    e.is_wr = 1'b1; e.addr = a; e.be = be; e.data = d;
    e.rid = 16'h0000; e.tag = 8'h00; e.laddr = 7'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [10:0] a, input logic [3:0] be, input logic [15:0] rid,
                         input logic [7:0] tag, input logic [6:0] laddr);
    exp_t e;
    e.is_wr = 1'b0; e.addr = a; e.be = {4'h0, be}; e.data = 32'h0;
    e.rid = rid; e.tag = tag; e.laddr = laddr;
    exp_q.push_back(e);
  endtask

  // Present one beat at a negedge and hold it until the following posedge accepts it.
  task automatic send_beat(input logic [63:0] d, input logic last);
    int waited = 0;
    rx_tdata = d; rx_tlast = last; rx_tvalid = 1'b1; rx_tkeep = 8'hFF;
    while (rx_tready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("beat_accept", 64'(rx_tready), 64'd1);
    @(negedge clk);
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  // Scoreboard: every wr_en / req_compl pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (wr_en === 1'b1 || req_compl === 1'b1)) begin
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed wr_en=%b req_compl=%b expected no access", wr_en, req_compl);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_wr_en", 64'(wr_en), 64'(e.is_wr));
        check("sb_req_compl", 64'(req_compl), 64'(!e.is_wr));
        if (e.is_wr) begin
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_be", 64'(wr_be), 64'(e.be));
          check("wr_data", 64'(wr_data), 64'(e.data));
          last_wr_cyc = cyc;
        end else begin
          check("rd_addr", 64'(rd_addr), 64'(e.addr));
          check("rd_be", 64'(rd_be), 64'(e.be));
          check("req_rid", 64'(req_rid), 64'(e.rid));
          check("req_tag", 64'(req_tag), 64'(e.tag));
          check("req_len", 64'(req_len), 64'd1);
          check("req_addr", 64'(req_addr), 64'(e.laddr));
          last_cpl_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_tdata = 64'h0; rx_tkeep = 8'h00; rx_tlast = 1'b0; rx_tvalid = 1'b0;
    wr_busy = 1'b0; compl_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tready", 64'(rx_tready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_req_compl", 64'(req_compl), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_discard_cnt", 64'(discard_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tready", 64'(rx_tready), 64'd1);

    // MWr32 register write
    push_wr(11'd2, 8'h0F, 32'h12345678);
    send_beat(64'h0100000F_40000001, 1'b0);
    send_beat(64'h78563412_00000008, 1'b1);
    repeat (4) @(negedge clk);

    // MRd32 read, completion returned 10 cycles later
    push_rd(11'd4, 4'hF, 16'h0100, 8'h2A, 7'h10);
    send_beat(64'h01002A0F_00000001, 1'b0);
    send_beat(64'h00000000_00000010, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("cpl_wait_tready", 64'(rx_tready), 64'd0);
      check("cpl_wait_rd_addr", 64'(rd_addr), 64'd4);
      @(negedge clk);
    end
    check("cpl_wait_req_tag", 64'(req_tag), 64'h2A);
    compl_done = 1'b1;
    @(negedge clk);
    compl_done = 1'b0;
    check("cpl_done_tready", 64'(rx_tready), 64'd1);

    // MWr64 three-beat write while the register file is busy
    wr_busy = 1'b1;
    push_wr(11'h27, 8'h0F, 32'h00000001);
    send_beat(64'h0100000F_60000001, 1'b0);
    send_beat(64'h0000009C_00000000, 1'b0);
    send_beat(64'hDEADBEEF_01000000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("wr_busy_tready", 64'(rx_tready), 64'd0);
      @(negedge clk);
    end
    wr_busy = 1'b0;
    @(negedge clk);
    check("wr_busy_release_tready", 64'(rx_tready), 64'd1);

    // Unsupported CplD and MRd with len 2
    send_beat(64'h01000004_4A000001, 1'b0);
    send_beat(64'h11111111_22222222, 1'b0);
    send_beat(64'h33333333_44444444, 1'b1);
    send_beat(64'h0100000F_00000002, 1'b0);
    send_beat(64'h00000000_00000010, 1'b1);
    @(negedge clk);
    check("discard_cnt_2", 64'(discard_cnt), 64'(2 * DROP_STEP));
    check("discard_idle_tready", 64'(rx_tready), 64'd1);

    // Early tlast on MWr64 address beat, then a header-only MWr32
    send_beat(64'h0100000F_60000001, 1'b0);
    send_beat(64'h0000009C_00000000, 1'b1);
    send_beat(64'h0100000F_40000001, 1'b1);
    @(negedge clk);
    check("discard_cnt_4", 64'(discard_cnt), 64'(4 * DROP_STEP));

    // Reset while waiting for a completion
    push_rd(11'd4, 4'hF, 16'h0100, 8'h2A, 7'h10);
    send_beat(64'h01002A0F_00000001, 1'b0);
    send_beat(64'h00000000_00000010, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_tready", 64'(rx_tready), 64'd0);
    check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
    check("mid_rst_req_tag", 64'(req_tag), 64'd0);
    check("mid_rst_req_rid", 64'(req_rid), 64'd0);
    check("mid_rst_wr_be", 64'(wr_be), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("mid_rst_discard_cnt", 64'(discard_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tready", 64'(rx_tready), 64'd1);
    push_wr(11'h3FF, 8'hC3, 32'hDEADBEEF);
    send_beat(64'h00AB00C3_40000001, 1'b0);
    send_beat(64'hEFBEADDE_00000FFC, 1'b1);
    repeat (4) @(negedge clk);

    // Back-to-back MWr32 then MRd32
    last_cpl_cyc = -1;
    push_wr(11'd5, 8'h0F, 32'h11223344);
    push_rd(11'h1F, 4'h3, 16'h0200, 8'h55, 7'h7C);
    send_beat(64'h0100000F_40000001, 1'b0);
    send_beat(64'h44332211_00000014, 1'b1);
    send_beat(64'h02005503_00000001, 1'b0);
    send_beat(64'h00000000_0000007C, 1'b1);
    @(negedge clk);
    n_assert++;
    assert (last_cpl_cyc - last_wr_cyc >= 3) else begin
      n_fail++;
      $error("FAIL b2b_gap: observed %0d cycles expected >= 3", last_cpl_cyc - last_wr_cyc);
    end
    compl_done = 1'b1;
    @(negedge clk);
    compl_done = 1'b0;
    check("b2b_done_tready", 64'(rx_tready), 64'd1);

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
